// File: rtl/otter_wb_queue_if.sv
// Bus bundle between the writeback queue, its producers, the core writeback
// path, the register-file write port and the forwarding lookups.
interface otter_wb_queue_if #(
    parameter int XLEN = 32
);
    // producer side
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;
    // core writeback, owns the port when asserted
    logic            core_we;
    logic [4:0]      core_rd;
    logic [XLEN-1:0] core_data;
    // register file write port
    logic            RegWrite;
    logic [4:0]      WriteReg;
    logic [XLEN-1:0] WriteData;
    // forwarding lookups
    logic [4:0]      q_addr1;
    logic [4:0]      q_addr2;
    logic            q_hit1;
    logic            q_hit2;
    logic [XLEN-1:0] q_data1;
    logic [XLEN-1:0] q_data2;
    // status
    logic            empty;
    logic            full;

    modport slave (
        input  in_valid, in_rd, in_data, core_we, core_rd, core_data,
               q_addr1, q_addr2,
        output in_ready, RegWrite, WriteReg, WriteData,
               q_hit1, q_hit2, q_data1, q_data2, empty, full
    );

    modport master (
        output in_valid, in_rd, in_data, core_we, core_rd, core_data,
               q_addr1, q_addr2,
        input  in_ready, RegWrite, WriteReg, WriteData,
               q_hit1, q_hit2, q_data1, q_data2, empty, full
    );
endinterface

// File: rtl/otter_wb_queue.sv
// Writeback queue in front of the OTTER register file write port. Buffers
// long-latency results, drains one per idle core cycle, squashes entries made
// stale by younger core writes, and forwards pending values to the read ports.
module otter_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic              clock,
    input  logic              reset,
    otter_wb_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [DEPTH-1:0]           live_q, live_d;
    logic [DEPTH-1:0][4:0]      rd_q, rd_d;
    logic [DEPTH-1:0][XLEN-1:0] data_q, data_d;
    ptr_t                       wptr_q, wptr_d, rptr_q, rptr_d;
    cnt_t                       count_q, count_d;

    logic full, empty, accept, store, pop, squash;
    logic            reg_write;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic            hit1, hit2;
    logic [XLEN-1:0] fwd1, fwd2;

    // Occupancy comes from the counter so wrap never aliases full with empty.
    assign full   = (count_q == cnt_t'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = bus.in_valid && !full && !reset;
    // x0 results are handshaken but never occupy a slot.
    assign store  = accept && (bus.in_rd != 5'd0);
    assign pop    = !bus.core_we && !empty;
    assign squash = bus.core_we && (bus.core_rd != 5'd0);

    assign bus.in_ready  = !full && !reset;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.RegWrite  = reg_write;
    assign bus.WriteReg  = write_reg;
    assign bus.WriteData = write_data;
    assign bus.q_hit1    = hit1;
    assign bus.q_hit2    = hit2;
    assign bus.q_data1   = fwd1;
    assign bus.q_data2   = fwd2;

    // Write-port mux: core first, otherwise the head (a dead head drains silently).
    always_comb begin
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = '0;
        if (bus.core_we) begin
            reg_write  = 1'b1;
            write_reg  = bus.core_rd;
            write_data = bus.core_data;
        end else if (!empty) begin
            reg_write  = live_q[rptr_q];
            write_reg  = rd_q[rptr_q];
            write_data = data_q[rptr_q];
        end
    end

    // Forwarding: scan oldest to youngest so the youngest live match wins.
    // Slots outside the held window are never live, so no range check is needed.
    always_comb begin
        ptr_t idx;
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = wptr_q - ptr_t'(k + 1);
            if (live_q[idx] && bus.q_addr1 != 5'd0 && rd_q[idx] == bus.q_addr1) begin
                hit1 = 1'b1;
                fwd1 = data_q[idx];
            end
            if (live_q[idx] && bus.q_addr2 != 5'd0 && rd_q[idx] == bus.q_addr2) begin
                hit2 = 1'b1;
                fwd2 = data_q[idx];
            end
        end
    end

    // Next state: squash stale entries, retire the head, append the new result.
    // A same-cycle push to the core's rd is older than the core write, so it lands dead.
    always_comb begin
        live_d  = live_q;
        rd_d    = rd_q;
        data_d  = data_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash && rd_q[i] == bus.core_rd) live_d[i] = 1'b0;
        end
        if (pop) begin
            live_d[rptr_q] = 1'b0;
            rptr_d         = rptr_q + ptr_t'(1);
        end
        if (store) begin
            live_d[wptr_q] = !(squash && bus.in_rd == bus.core_rd);
            rd_d[wptr_q]   = bus.in_rd;
            data_d[wptr_q] = bus.in_data;
            wptr_d         = wptr_q + ptr_t'(1);
        end
        count_d = count_q + cnt_t'(store) - cnt_t'(pop);
    end

    // State registers; reset discards every held entry, overriding any pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            live_q  <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            live_q  <= live_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_otter_wb_queue.sv
// Directed bench for otter_wb_queue: a cycle table for the basic, priority,
// squash and forwarding cases, plus sequences for full/wrap and mid-stream reset.
module tb_otter_wb_queue;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    otter_wb_queue_if #(.XLEN(32)) bus ();

    otter_wb_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] idat;
        logic        cwe;
        logic [4:0]  crd;
        logic [31:0] cdat;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
        logic        e_emp;
        logic        e_full;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    vec_t vecs[$];
    ent_t model[$];

    function automatic vec_t mk(
        input logic rst, input logic iv, input logic [4:0] ird, input logic [31:0] idat,
        input logic cwe, input logic [4:0] crd, input logic [31:0] cdat,
        input logic [4:0] a1, input logic [4:0] a2,
        input logic rdy, input logic we, input logic [4:0] wr, input logic [31:0] wd,
        input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2,
        input logic emp, input logic full);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ird = ird; v.idat = idat;
        v.cwe = cwe; v.crd = crd; v.cdat = cdat; v.a1 = a1; v.a2 = a2;
        v.e_rdy = rdy; v.e_we = we; v.e_wr = wr; v.e_wd = wd;
        v.e_h1 = h1; v.e_d1 = d1; v.e_h2 = h2; v.e_d2 = d2;
        v.e_emp = emp; v.e_full = full;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] ird, input logic [31:0] idat,
                         input logic cwe, input logic [4:0] crd, input logic [31:0] cdat);
        bus.in_valid  = iv;
        bus.in_rd     = ird;
        bus.in_data   = idat;
        bus.core_we   = cwe;
        bus.core_rd   = crd;
        bus.core_data = cdat;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.q_addr1 = 5'd0;
        bus.q_addr2 = 5'd0;

        // rst iv ird idat      cwe crd cdat    a1 a2 | rdy we wr wd  h1 d1  h2 d2  emp full
        vecs.push_back(mk(1,1,5,32'hDEADBEEF,0,0,0,     5,0, 0,0,0,0,            0,0,0,0,1,0));
        vecs.push_back(mk(0,1,5,32'hDEADBEEF,0,0,0,     5,0, 1,0,0,0,            0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     5,0, 1,1,5,32'hDEADBEEF, 1,32'hDEADBEEF,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     5,0, 1,0,0,0,            0,0,0,0,1,0));
        // core priority
        vecs.push_back(mk(0,1,3,32'h11,      0,0,0,     3,4, 1,0,0,0,            0,0,0,0,1,0));
        vecs.push_back(mk(0,1,4,32'h22,      1,7,32'h77,3,4, 1,1,7,32'h77,       1,32'h11,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,           1,7,32'h77,3,4, 1,1,7,32'h77,       1,32'h11,1,32'h22,0,0));
        vecs.push_back(mk(0,0,0,0,           1,7,32'h77,3,4, 1,1,7,32'h77,       1,32'h11,1,32'h22,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     3,4, 1,1,3,32'h11,       1,32'h11,1,32'h22,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     3,4, 1,1,4,32'h22,       0,0,1,32'h22,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     3,4, 1,0,0,0,            0,0,0,0,1,0));
        // WAW squash, core write a cycle after the push
        vecs.push_back(mk(0,1,9,32'hAA,      0,0,0,     9,0, 1,0,0,0,            0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,           1,9,32'hBB,9,0, 1,1,9,32'hBB,       1,32'hAA,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     9,0, 1,0,9,32'hAA,       0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     9,0, 1,0,0,0,            0,0,0,0,1,0));
        // WAW squash, push and core write in the same cycle
        vecs.push_back(mk(0,1,9,32'hAA,      1,9,32'hBB,9,0, 1,1,9,32'hBB,       0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     9,0, 1,0,9,32'hAA,       0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     9,0, 1,0,0,0,            0,0,0,0,1,0));
        // forwarding youngest, x0 push accepted but not stored
        vecs.push_back(mk(0,1,6,32'h1,       1,7,32'h77,6,0, 1,1,7,32'h77,       0,0,0,0,1,0));
        vecs.push_back(mk(0,1,6,32'h2,       1,7,32'h77,6,0, 1,1,7,32'h77,       1,32'h1,0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h55,      1,7,32'h77,6,0, 1,1,7,32'h77,       1,32'h2,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,           1,7,32'h77,6,6, 1,1,7,32'h77,       1,32'h2,1,32'h2,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     6,6, 1,1,6,32'h1,        1,32'h2,1,32'h2,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     6,6, 1,1,6,32'h2,        1,32'h2,1,32'h2,0,0));
        vecs.push_back(mk(0,0,0,0,           0,0,0,     6,6, 1,0,0,0,            0,0,0,0,1,0));

        repeat (2) @(posedge clock);

        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst;
            drive(vecs[i].iv, vecs[i].ird, vecs[i].idat, vecs[i].cwe, vecs[i].crd, vecs[i].cdat);
            bus.q_addr1 = vecs[i].a1;
            bus.q_addr2 = vecs[i].a2;
            #2;
            chk($sformatf("v%0d in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_rdy));
            chk($sformatf("v%0d RegWrite", i),  32'(bus.RegWrite),  32'(vecs[i].e_we));
            chk($sformatf("v%0d WriteReg", i),  32'(bus.WriteReg),  32'(vecs[i].e_wr));
            chk($sformatf("v%0d WriteData", i), bus.WriteData,      vecs[i].e_wd);
            chk($sformatf("v%0d q_hit1", i),    32'(bus.q_hit1),    32'(vecs[i].e_h1));
            chk($sformatf("v%0d q_data1", i),   bus.q_data1,        vecs[i].e_d1);
            chk($sformatf("v%0d q_hit2", i),    32'(bus.q_hit2),    32'(vecs[i].e_h2));
            chk($sformatf("v%0d q_data2", i),   bus.q_data2,        vecs[i].e_d2);
            chk($sformatf("v%0d empty", i),     32'(bus.empty),     32'(vecs[i].e_emp));
            chk($sformatf("v%0d full", i),      32'(bus.full),      32'(vecs[i].e_full));
        end

        // Fill to DEPTH behind a busy core, then stream through the pointer wrap.
        bus.q_addr1 = 5'd0;
        bus.q_addr2 = 5'd0;
        model.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1, 5'd7, 32'h77);
            #2;
            chk($sformatf("fill%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            model.push_back('{rd: 5'(10 + i), data: 32'h100 + 32'(i)});
        end
        @(negedge clock);
        drive(1'b1, 5'd20, 32'hBAD, 1'b1, 5'd7, 32'h77);
        #2;
        chk("full flag", 32'(bus.full), 32'd1);
        chk("full in_ready", 32'(bus.in_ready), 32'd0);
        begin
            int         k;
            logic [4:0] pv_rd;
            logic [31:0] pv_data;
            logic       exp_rdy;
            k       = 0;
            pv_rd   = 5'd1;
            pv_data = 32'h200;
            for (int c = 0; c < 12; c++) begin
                @(negedge clock);
                drive(1'b1, pv_rd, pv_data, 1'b0, 5'd0, 32'h0);
                #2;
                exp_rdy = (model.size() < 4);
                chk($sformatf("wrap%0d in_ready", c), 32'(bus.in_ready), 32'(exp_rdy));
                chk($sformatf("wrap%0d full", c), 32'(bus.full), 32'(model.size() == 4));
                chk($sformatf("wrap%0d RegWrite", c), 32'(bus.RegWrite), 32'd1);
                chk($sformatf("wrap%0d WriteReg", c), 32'(bus.WriteReg), 32'(model[0].rd));
                chk($sformatf("wrap%0d WriteData", c), bus.WriteData, model[0].data);
                void'(model.pop_front());
                if (exp_rdy) begin
                    model.push_back('{rd: pv_rd, data: pv_data});
                    k++;
                    pv_rd   = 5'(1 + (k % 31));
                    pv_data = 32'h200 + 32'(k);
                end
            end
        end
        for (int c = 0; c < 8 && model.size() > 0; c++) begin
            @(negedge clock);
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            #2;
            chk($sformatf("drain%0d RegWrite", c), 32'(bus.RegWrite), 32'd1);
            chk($sformatf("drain%0d WriteReg", c), 32'(bus.WriteReg), 32'(model[0].rd));
            chk($sformatf("drain%0d WriteData", c), bus.WriteData, model[0].data);
            void'(model.pop_front());
        end
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        chk("drain empty", 32'(bus.empty), 32'd1);
        chk("drain RegWrite", 32'(bus.RegWrite), 32'd0);

        // Three held entries, reset pulsed during what would be a drain cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1'b1, 5'(12 + i), 32'hC0 + 32'(i), 1'b1, 5'd7, 32'h77);
        end
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.q_addr1 = 5'd12;
        bus.q_addr2 = 5'd14;
        #2;
        chk("rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("rst WriteReg", 32'(bus.WriteReg), 32'd12);
        chk("rst WriteData", bus.WriteData, 32'hC0);
        chk("rst q_hit2", 32'(bus.q_hit2), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #2;
        chk("post empty", 32'(bus.empty), 32'd1);
        chk("post RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("post q_hit1", 32'(bus.q_hit1), 32'd0);
        chk("post q_hit2", 32'(bus.q_hit2), 32'd0);
        chk("post q_data1", bus.q_data1, 32'd0);
        chk("post in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        #2;
        chk("post2 RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("post2 empty", 32'(bus.empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/otter_wb_queue.md
Name: otter_wb_queue

Overview:
- Writeback queue that sits in front of the OTTER register file's single write port (RegWrite/WriteReg/WriteData).
- Buffers results from long-latency units (memory loads, a future multiplier/divider) and drains them into the register file one entry per cycle.
- The core's own writeback always has priority on the port; queue drains only in cycles the core does not write.
- Provides forwarding lookups on the two read addresses, so pending results are visible before they reach the register file.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- XLEN, 32, data width.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- in_valid  in  1  producer has a result.
- in_ready  out  1  queue can accept this cycle.
- in_rd  in  5  destination register.
- in_data  in  XLEN  result value.
- core_we  in  1  core writeback this cycle; owns the port.
- core_rd  in  5  core destination register.
- core_data  in  XLEN  core result.
- RegWrite  out  1  to register file write enable.
- WriteReg  out  5  to register file write address.
- WriteData  out  XLEN  to register file write data.
- q_addr1, q_addr2  in  5 each  lookup addresses, tied to Read1/Read2.
- q_hit1, q_hit2  out  1 each  a live pending entry targets the address.
- q_data1, q_data2  out  XLEN each  youngest live pending value for the address.
- empty  out  1  no entries held.
- full  out  1  DEPTH entries held.

Behaviour:
- Storage: circular buffer of DEPTH entries. Each entry holds {live, rd, data}. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset: count=0, pointers=0, all live=0. While reset is high, in_ready=0. After reset: empty=1, full=0, q_hit*=0, q_data*=0, and RegWrite=core_we.
- Handshake:
  - in_ready = !full && !reset.
  - Push occurs when in_valid && in_ready at posedge.
  - There is no combinational pass-through. Push-to-earliest-write latency is 1 cycle.
  - in_valid while full has no effect; the producer holds its value until ready.
- x0 handling: a push with in_rd==0 is accepted (in_ready honoured) but stores nothing. Count is unchanged.
- Port mux, combinational:
  - If core_we: RegWrite=1 (core_rd==0 is left to the register file to ignore), WriteReg=core_rd, WriteData=core_data. The queue does not pop.
  - Else if not empty: pop the head at posedge. RegWrite = head.live, WriteReg = head.rd, WriteData = head.data.
  - Else RegWrite=0, WriteReg=0, WriteData=0.
- Ordering (WAW) rule: a core write is program-order younger than every queued entry, including one pushed in the same cycle.
  - When core_we && core_rd!=0, every held entry with rd==core_rd has live cleared at that posedge.
  - A same-cycle push with in_rd==core_rd is stored with live=0.
  - A dead head still pops in its drain cycle with RegWrite=0.
- Simultaneous push and pop: both take effect; count is unchanged. This is legal only when not full, because in_ready already blocks a push when full.
- Forwarding, combinational:
  - q_hitN=1 if any held entry is live and has rd==q_addrN, with q_addrN!=0.
  - q_dataN is the youngest such entry, measured from the write pointer backwards; 0 when no hit.
  - The head entry still counts as pending during its drain cycle. The register file holds the value from the next cycle on.
- Reset mid-operation: all held entries are discarded; nothing is written. Reset asserted during a drain cycle: RegWrite follows the mux for that cycle, but the pop is superseded by the reset.
- Pointer wrap: correct across any number of wraps. full and empty are derived from count, never from pointer equality alone.

Test Plan:
- Basic drain: push (rd=5, 0xDEADBEEF) with core_we=0 -> next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; following cycle empty=1 and RegWrite=0.
- Core priority: push rd=3, 0x11 and rd=4, 0x22; hold core_we=1 (rd=7, 0x77) for 3 cycles -> port shows 7/0x77 each cycle, count stays 2; then drains 3/0x11 and 4/0x22 on consecutive cycles.
- Full/wrap: with core_we=1, push DEPTH=4 entries -> full=1, in_ready=0, a 5th in_valid is ignored. Release core_we while pushing continuously for 12 cycles -> entries drain in push order across pointer wrap, none lost or duplicated.
- WAW squash: queue rd=9, 0xAA; core_we with rd=9, 0xBB -> q_hit1(addr 9)=0 after the edge; the entry pops later with RegWrite=0, so the register file keeps 0xBB. Repeat with the push and core write in the same cycle -> same result.
- Forwarding: queue rd=6, 0x1 then rd=6, 0x2 with core_we=1 -> q_addr1=6 gives hit=1, data=0x2. q_addr2=0 gives hit=0, data=0. Push rd=0 -> accepted, count unchanged.
- Reset mid-stream: 3 entries held, pulse reset 1 cycle -> next cycle empty=1, q_hit*=0, in_ready=1, no writes of the discarded entries.
